// File: rtl/scpu_selftest_seq_pkg.sv
// Shared types and defaults for the serial CPU self-test sequencer.
// States, pipeline-slot kinds and a parameter range helper.
package scpu_selftest_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_D,
    S_START,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_I,
    K_D,
    K_C
  } kind_t;

  localparam int DEF_TIMEOUT = 320;

  function automatic bit fits(longint n, int w);
    return n < (longint'(1) << w);
  endfunction

endpackage

// File: rtl/scpu_selftest_seq_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used for the error and RUN-cycle counts.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  // count up, stick at all-ones
  always_ff @(posedge clk) begin
    if (rst || clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + CNT_W'(1);
  end

endmodule

// File: rtl/scpu_selftest_seq.sv
// Self-test sequencer: load I/D memory from a table, run the CPU,
// then compare result words in D memory against the table.
module scpu_selftest_seq
  import scpu_selftest_seq_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int PROG_LEN  = 7,
  parameter int DINIT_LEN = 3,
  parameter int CHK_LEN   = 1,
  parameter int CHK_BASE  = 2,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              cpu_enable,
  output logic              cpu_start,
  input  logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int C_OFF = PROG_LEN + DINIT_LEN;
  localparam int T_END = C_OFF + CHK_LEN;

  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_I  = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_D  = ADDR_W'(C_OFF - 1);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(T_END - 1);
  localparam logic [ADDR_W-1:0] D_OFF_A = ADDR_W'(PROG_LEN);
  localparam logic [ADDR_W-1:0] C_OFF_A = ADDR_W'(C_OFF);
  localparam logic [ADDR_W-1:0] CBASE_A = ADDR_W'(CHK_BASE);
  localparam logic [CNT_W-1:0]  T_LIM   = CNT_W'(TIMEOUT - 1);

  if (!fits(T_END, ADDR_W) || !fits(CHK_BASE + CHK_LEN, ADDR_W) ||
      !fits(TIMEOUT, CNT_W) || PROG_LEN < 1 || TIMEOUT < 1 ||
      DINIT_LEN < 0 || CHK_LEN < 0) begin : g_bad_params
    $error("scpu_selftest_seq: parameter out of range");
  end

  state_t            st_q, st_n;
  kind_t             knd_q, knd_n;
  logic [ADDR_W-1:0] tbl_q, tbl_n;
  logic [ADDR_W-1:0] rad_q, rad_n;
  logic [ADDR_W-1:0] wad_q, wad_n;
  logic              vld_q, vld_n;
  logic              last_q, last_n;
  logic              to_q, to_n;
  logic              clr;
  logic              err_inc;

  // state, address counters and the 1-cycle write/compare slot
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_IDLE;
      knd_q  <= K_I;
      tbl_q  <= '0;
      rad_q  <= '0;
      wad_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      st_q   <= st_n;
      knd_q  <= knd_n;
      tbl_q  <= tbl_n;
      rad_q  <= rad_n;
      wad_q  <= wad_n;
      vld_q  <= vld_n;
      last_q <= last_n;
      to_q   <= to_n;
    end
  end

  // next state and next-cycle table/memory slot
  always_comb begin
    st_n   = st_q;
    knd_n  = K_I;
    tbl_n  = tbl_q;
    rad_n  = rad_q;
    wad_n  = wad_q;
    vld_n  = 1'b0;
    last_n = 1'b0;
    to_n   = to_q;
    clr    = 1'b0;
    unique case (st_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          st_n  = S_LOAD_I;
          tbl_n = '0;
          to_n  = 1'b0;
          clr   = 1'b1;
        end
      end
      S_LOAD_I: begin
        vld_n = 1'b1;
        knd_n = K_I;
        wad_n = tbl_q;
        tbl_n = tbl_q + A_ONE;
        if (tbl_q == LAST_I)
          st_n = (DINIT_LEN > 0) ? S_LOAD_D : S_START;
      end
      S_LOAD_D: begin
        vld_n = 1'b1;
        knd_n = K_D;
        wad_n = tbl_q - D_OFF_A;
        tbl_n = tbl_q + A_ONE;
        if (tbl_q == LAST_D)
          st_n = S_START;
      end
      S_START: begin
        st_n = S_RUN;
      end
      S_RUN: begin
        if (cpu_halt) begin
          if (CHK_LEN > 0) begin
            st_n  = S_CHECK;
            tbl_n = C_OFF_A;
            rad_n = CBASE_A;
          end else begin
            st_n = S_DONE;
          end
        end else if (cycle_count >= T_LIM) begin
          st_n = S_DONE;
          to_n = 1'b1;
        end
      end
      S_CHECK: begin
        if (last_q) begin
          st_n = S_DONE;
        end else begin
          vld_n = 1'b1;
          knd_n = K_C;
          if (tbl_q == LAST_C) begin
            last_n = 1'b1;
          end else begin
            tbl_n = tbl_q + A_ONE;
            rad_n = rad_q + A_ONE;
          end
        end
      end
      default: st_n = S_IDLE;
    endcase
  end

  assign err_inc = vld_q && (knd_q == K_C) && (tbl_data != dm_rdata);

  sat_counter #(.CNT_W(CNT_W)) u_err (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_inc),
    .q   (err_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (st_q == S_RUN),
    .q   (cycle_count)
  );

  assign tbl_addr    = tbl_q;
  assign im_we       = vld_q && (knd_q == K_I);
  assign dm_we       = vld_q && (knd_q == K_D);
  assign im_addr     = im_we ? wad_q : '0;
  assign im_wdata    = im_we ? tbl_data : '0;
  assign dm_addr     = dm_we ? wad_q : rad_q;
  assign dm_wdata    = dm_we ? tbl_data : '0;
  assign cpu_enable  = (st_q == S_START) || (st_q == S_RUN);
  assign cpu_start   = (st_q == S_START);
  assign busy        = (st_q != S_IDLE) && (st_q != S_DONE);
  assign done        = (st_q == S_DONE);
  assign timed_out   = to_q;
  assign pass        = done && !to_q && (err_count == '0);

endmodule
